// File: rtl/mult_pkg.sv
// mult_pkg: shared widths and types for the shift-add multiplier datapath
package mult_pkg;
    localparam int N = 4;
    localparam int PW = 2 * N;
    typedef logic [N-1:0] operand_t;
    typedef logic [PW-1:0] product_t;
endpackage

// File: rtl/mult_result_buf.sv
// mult_result_buf: product holding register with valid/ready handshake
// Sticky overrun flag present only when MULT_DP_OVERRUN_EN is defined.
module mult_result_buf
    import mult_pkg::*;
#(
    parameter int PW = mult_pkg::PW
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          finish,
    input  logic [PW-1:0] sum,
    input  logic          prod_ready,
    output logic [PW-1:0] product,
    output logic          prod_valid
`ifdef MULT_DP_OVERRUN_EN
    ,
    output logic          overrun
`endif
);
    // A finish in the same cycle as an accept keeps the new result valid
    always_ff @(posedge clk)
        if (!reset_n) begin
            product <= '0;
            prod_valid <= 1'b0;
        end else if (finish) begin
            product <= sum;
            prod_valid <= 1'b1;
        end else if (prod_ready)
            prod_valid <= 1'b0;

`ifdef MULT_DP_OVERRUN_EN
    always_ff @(posedge clk)
        overrun <= !reset_n ? 1'b0 : overrun | (finish & prod_valid & ~prod_ready);
`endif
endmodule

// File: rtl/mult4bit_datapath.sv
// mult4bit_datapath: shift-add multiplier datapath executing init/plus/shift/finish strobes
// Define MULT_DP_OVERRUN_EN to add the sticky overrun output.
module mult4bit_datapath
    import mult_pkg::*;
#(
    parameter int N = mult_pkg::N
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic [N-1:0]   a_in,
    input  logic [N-1:0]   b_in,
    input  logic           init,
    input  logic           plus,
    input  logic           shift,
    input  logic           finish,
    output logic [N-1:0]   B,
    output logic [2*N-1:0] product,
    output logic           prod_valid,
    input  logic           prod_ready
`ifdef MULT_DP_OVERRUN_EN
    ,
    output logic           overrun
`endif
);
    logic [2*N-1:0] a;
    logic [2*N-1:0] p;
    logic           fin;

    // finish only takes effect when no higher-priority strobe is present
    assign fin = finish & ~(init | plus | shift);

    always_ff @(posedge clk)
        if (!reset_n) begin
            a <= '0;
            B <= '0;
            p <= '0;
        end else if (init) begin
            a <= {{N{1'b0}}, a_in};
            B <= b_in;
            p <= '0;
        end else if (plus) begin
            p <= p + a;
            B[0] <= 1'b0;
        end else if (shift) begin
            a <= a << 1;
            B <= B >> 1;
        end

    mult_result_buf #(.PW(2 * N)) u_buf (
        .clk        (clk),
        .reset_n    (reset_n),
        .finish     (fin),
        .sum        (p),
        .prod_ready (prod_ready),
        .product    (product),
        .prod_valid (prod_valid)
`ifdef MULT_DP_OVERRUN_EN
        ,
        .overrun    (overrun)
`endif
    );
endmodule

// File: tb/tb_mult4bit_datapath.sv
// tb_mult4bit_datapath: table-driven and scoreboarded bench with a behavioural controller
// Overrun checks are active when MULT_DP_OVERRUN_EN is defined.
module tb_mult4bit_datapath;
    import mult_pkg::*;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    operand_t a_in = '0, b_in = '0;
    logic init = 1'b0, plus = 1'b0, shift = 1'b0, finish = 1'b0;
    operand_t B;
    product_t product;
    logic prod_valid;
    logic prod_ready = 1'b0;
`ifdef MULT_DP_OVERRUN_EN
    logic overrun;
`endif

    int compared = 0;
    int mismatched = 0;
    product_t sb[$];

    typedef struct {
        operand_t a;
        operand_t b;
        product_t prod;
        int       n_plus;
        int       n_shift;
    } vec_t;
    vec_t vecs[7];

    always #5 clk = ~clk;

    mult4bit_datapath dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .a_in       (a_in),
        .b_in       (b_in),
        .init       (init),
        .plus       (plus),
        .shift      (shift),
        .finish     (finish),
        .B          (B),
        .product    (product),
        .prod_valid (prod_valid),
        .prod_ready (prod_ready)
`ifdef MULT_DP_OVERRUN_EN
        ,
        .overrun    (overrun)
`endif
    );

    task automatic check(input string name, input int act, input int exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Controller model: branches on B each cycle; aborts with reset after abort_after cycles
    task automatic run(input operand_t a, input operand_t b, input logic rdy_fin,
                       input int abort_after, output int np, output int ns);
        logic done;
        np = 0;
        ns = 0;
        done = 1'b0;
        @(negedge clk);
        a_in = a;
        b_in = b;
        init = 1'b1;
        sb.push_back(product_t'(a) * product_t'(b));
        @(negedge clk);
        init = 1'b0;
        for (int cyc = 0; cyc < 20 && !done; cyc++) begin
            if (abort_after != 0 && cyc == abort_after) begin
                reset_n = 1'b0;
                sb.delete();
                done = 1'b1;
            end else if (B == '0) begin
                finish = 1'b1;
                prod_ready = rdy_fin;
                done = 1'b1;
            end else if (B[0]) begin
                plus = 1'b1;
                np++;
            end else begin
                shift = 1'b1;
                ns++;
            end
            @(negedge clk);
            plus = 1'b0;
            shift = 1'b0;
            finish = 1'b0;
            prod_ready = 1'b0;
        end
        if (!done)
            check("timeout", 0, 1);
        else if (abort_after == 0) begin
            check("valid_after_finish", int'(prod_valid), 1);
            if (sb.size() == 0)
                check("scoreboard_empty", 0, 1);
            else
                check("product", int'(product), int'(sb.pop_front()));
        end
    endtask

    task automatic consume();
        prod_ready = 1'b1;
        @(negedge clk);
        prod_ready = 1'b0;
        check("valid_cleared", int'(prod_valid), 0);
    endtask

    initial begin
        int np, ns;
        vecs[0] = '{4'd15, 4'd15, 8'd225, 4, 3};
        vecs[1] = '{4'd6,  4'd8,  8'd48,  1, 3};
        vecs[2] = '{4'd9,  4'd0,  8'd0,   0, 0};
        vecs[3] = '{4'd0,  4'd13, 8'd0,   3, 3};
        vecs[4] = '{4'd1,  4'd1,  8'd1,   1, 0};
        vecs[5] = '{4'd12, 4'd5,  8'd60,  2, 2};
        vecs[6] = '{4'd7,  4'd2,  8'd14,  1, 1};

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_B", int'(B), 0);
        check("reset_product", int'(product), 0);
        check("reset_valid", int'(prod_valid), 0);
`ifdef MULT_DP_OVERRUN_EN
        check("reset_overrun", int'(overrun), 0);
`endif
        reset_n = 1'b1;

        for (int i = 0; i < 7; i++) begin
            run(vecs[i].a, vecs[i].b, 1'b0, 0, np, ns);
            check($sformatf("vec%0d_product", i), int'(product), int'(vecs[i].prod));
            check($sformatf("vec%0d_plus", i), np, vecs[i].n_plus);
            check($sformatf("vec%0d_shift", i), ns, vecs[i].n_shift);
            consume();
        end

        // Finish coinciding with an accept: new result stays valid, no overrun
        run(4'd1, 4'd1, 1'b0, 0, np, ns);
        run(4'd12, 4'd5, 1'b1, 0, np, ns);
        check("finish_wins_product", int'(product), 60);
`ifdef MULT_DP_OVERRUN_EN
        check("no_overrun_when_ready", int'(overrun), 0);
`endif
        consume();

        // Unread result overwritten
        run(4'd3, 4'd5, 1'b0, 0, np, ns);
        run(4'd7, 4'd2, 1'b0, 0, np, ns);
        check("overwrite_product", int'(product), 14);
        check("overwrite_valid", int'(prod_valid), 1);
`ifdef MULT_DP_OVERRUN_EN
        check("overrun_set", int'(overrun), 1);
`endif
        consume();
`ifdef MULT_DP_OVERRUN_EN
        check("overrun_sticky", int'(overrun), 1);
`endif
        run(4'd2, 4'd2, 1'b0, 0, np, ns);
`ifdef MULT_DP_OVERRUN_EN
        check("overrun_kept_by_init", int'(overrun), 1);
`endif
        consume();

        // Reset mid-operation drops the partial product
        run(4'd15, 4'd15, 1'b0, 3, np, ns);
        check("midreset_B", int'(B), 0);
        check("midreset_product", int'(product), 0);
        check("midreset_valid", int'(prod_valid), 0);
`ifdef MULT_DP_OVERRUN_EN
        check("midreset_overrun", int'(overrun), 0);
`endif
        reset_n = 1'b1;
        run(4'd2, 4'd3, 1'b0, 0, np, ns);
        check("after_reset_product", int'(product), 6);
        consume();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
